dmac_burst_initiator: RTL
=========================

// Module: dmac_burst_initiator
// PURPOSE
//  Parametrised DMA read-request initiator: splits a copy job (src, dst, byte length) into
//  AXI4 INCR read bursts and pushes one matching write-metadata entry per burst into the
//  write-side FIFO. Tracks outstanding writes via the B channel and reports done only once
//  every write response has returned. Sits between the DMAC config regs and AR/meta-FIFO paths.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_BYTES    4  bytes per beat; power of 2, 1..128
//  MAX_BEATS    16  max beats per burst; power of 2, 1..256
//  LEN_W        16  width of byte_len_i
//  MAX_OUTS      4  max bursts issued but not yet acknowledged on B; 1..15
// PORTS
//  clk             in   1           clock, all logic on rising edge
//  rst             in   1           synchronous active-high reset
//  src_addr_i      in   ADDR_W      job source address, DATA_BYTES aligned
//  dst_addr_i      in   ADDR_W      job destination address, DATA_BYTES aligned
//  byte_len_i      in   LEN_W       job length in bytes; low log2(DATA_BYTES) bits ignored
//  start_i         in   1           job start, sampled only in IDLE
//  done_o          out  1           1 = IDLE (no job active)
//  err_o           out  1           sticky: some B response of the job had bresp != OKAY
//  araddr_o        out  ADDR_W      burst source address
//  arlen_o         out  8           beats-1
//  arsize_o        out  3           log2(DATA_BYTES), constant
//  arburst_o       out  2           2'b01 INCR, constant
//  arvalid_o       out  1           AR request
//  arready_i       in   1           AR accept
//  bvalid_i        in   1           write response valid
//  bresp_i         in   2           write response code
//  bready_o        out  1           write response ready
//  fifo_full_i     in   1           meta FIFO full
//  meta_awaddr_o   out  ADDR_W      burst destination address
//  meta_awlen_o    out  8           equals arlen_o
//  meta_awvalid_o  out  1           meta FIFO push strobe
// BEHAVIOUR
//  Reset: state=IDLE, done_o=1, err_o=0, arvalid_o=0, meta_awvalid_o=0, counters/addrs=0.
//  Reset mid-job abandons the job immediately; no further AR or push is issued.
//  States IDLE -> ISSUE -> DRAIN -> IDLE.
//  IDLE: on start_i with beat count (byte_len_i>>log2 DATA_BYTES) != 0, latch src, dst and
//   remaining beats, clear err_o, go ISSUE. Zero-beat start is ignored (stays IDLE, done_o=1).
//  Burst size, computed from registered state:
//   beats = min(MAX_BEATS, remaining, beats to next 4KB boundary of src,
//   beats to next 4KB boundary of dst). arlen_o = beats-1. No burst crosses 4KB on either side.
//  ISSUE: arvalid_o rises only when !fifo_full_i && outstanding < MAX_OUTS.
//   Once high, arvalid_o and all AR/meta fields hold stable until arready_i (AXI rule).
//   Holding continues even if fifo_full_i rises meanwhile.
//   AR handshake cycle (arvalid_o && arready_i): meta_awvalid_o=1 for exactly that cycle;
//   src, dst += beats*DATA_BYTES (mod 2^ADDR_W); remaining -= beats; outstanding++.
//   If remaining reaches 0 -> DRAIN. Otherwise next arvalid_o is allowed the following cycle.
//  bready_o = 1 in every state except during reset.
//   Each bvalid_i cycle: outstanding--. If bresp_i != 2'b00, err_o is set.
//   B beats seen in IDLE are dropped (no underflow).
//  Same-cycle AR handshake and B response: outstanding unchanged.
//  DRAIN: no AR. When outstanding==0 (including a decrement to 0 this cycle) -> IDLE next
//   cycle; done_o rises that cycle.
//  start_i outside IDLE is ignored. err_o holds until the next accepted start.
// TESTING
//  DATA_BYTES=4, MAX_BEATS=16, src=0x1000, dst=0x2000, len=256, arready=1, B returned 2 cycles
//   after each push -> 4 ARs, arlen=15, araddr 0x1000/1040/1080/10C0, 4 pushes, done after 4th B.
//  src=0x1FF0, dst=0x3000, len=128 -> arlen 3 @0x1FF0, then arlen 15 @0x2000, then arlen 11
//   @0x2040; meta addrs 0x3000/0x3010/0x3050.
//  Hold fifo_full_i=1 for 10 cycles after start -> arvalid_o stays 0; first AR the cycle after
//   full drops. Raise full while arvalid_o waits on arready_i=0 -> arvalid and fields stay stable.
//  MAX_OUTS=2, withhold B, len=512 -> exactly 2 ARs, then stall. One B releases exactly one AR.
//   A B response in the same cycle as an AR handshake leaves the count at 2.
//  len=3 or len=0 with start -> stays IDLE, done_o=1, no AR. Second B with bresp=2'b10 ->
//   err_o=1 at done; cleared by the next start.
//  Assert rst for 1 cycle after the 2nd AR of a 4-burst job -> all outputs at reset values next
//   cycle, no further AR; a new job afterwards completes normally.

Source files
------------

// File: rtl/dmac_burst_initiator.sv
// ---------------------------------------------------------------------------
// dmac_burst_initiator
//   DMA read-request initiator. Splits a copy job (src, dst, byte length) into
//   AXI4 INCR read bursts. For every accepted AR it pushes one write-metadata
//   entry (destination address + length) into the write-side FIFO. It counts
//   outstanding writes through the B channel and returns to IDLE (done_o=1)
//   only after every write response of the job has come back.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   src_addr_i          job source address (DATA_BYTES aligned)
//   dst_addr_i          job destination address (DATA_BYTES aligned)
//   byte_len_i          job length in bytes (sub-beat bits ignored)
//   start_i             job start, honoured only in IDLE
//   done_o              1 while no job is active
//   err_o               sticky: a B response of the job was not OKAY
//   araddr_o .. arvalid_o, arready_i     AXI4 AR channel
//   bvalid_i, bresp_i, bready_o          AXI4 B channel
//   fifo_full_i         write-metadata FIFO full
//   meta_awaddr_o, meta_awlen_o, meta_awvalid_o   metadata FIFO push
// ---------------------------------------------------------------------------
module dmac_burst_initiator #(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4,
    parameter int MAX_BEATS  = 16,
    parameter int LEN_W      = 16,
    parameter int MAX_OUTS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  byte_len_i,
    input  logic              start_i,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic              bvalid_i,
    input  logic [1:0]        bresp_i,
    output logic              bready_o,
    input  logic              fifo_full_i,
    output logic [ADDR_W-1:0] meta_awaddr_o,
    output logic [7:0]        meta_awlen_o,
    output logic              meta_awvalid_o
);

    localparam int SZ = $clog2(DATA_BYTES);
    // wide enough for the 4KB room (up to 4096 beats) and any beat count
    localparam int CW = (LEN_W > 13) ? LEN_W + 1 : 14;
    localparam int OW = 4;
    localparam logic [CW-1:0] MAX_B = CW'(MAX_BEATS);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [OW-1:0]     outs_q, outs_d;
    logic              arvalid_q, arvalid_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic [CW-1:0]     src_room, dst_room, rem_ext, beats;
    logic [ADDR_W-1:0] burst_bytes;
    logic [LEN_W-1:0]  start_beats;
    logic              hs, b_take;

    // Burst size from registered state only, so the AR/meta fields cannot
    // move while arvalid_o waits for arready_i.
    always_comb begin
        src_room = (CW'(4096) - CW'(src_q[11:0])) >> SZ;
        dst_room = (CW'(4096) - CW'(dst_q[11:0])) >> SZ;
        rem_ext  = CW'(rem_q);
        beats    = MAX_B;
        if (rem_ext < beats)  beats = rem_ext;
        if (src_room < beats) beats = src_room;
        if (dst_room < beats) beats = dst_room;
        burst_bytes = ADDR_W'(beats) << SZ;
        start_beats = byte_len_i >> SZ;
    end

    // Reset gates the handshake so nothing is issued in the reset cycle.
    assign hs     = arvalid_q & arready_i & ~rst;
    // B beats outside a job, or with nothing outstanding, are dropped.
    assign b_take = bvalid_i && (state_q != IDLE) && ((outs_q != '0) || hs);

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        arvalid_d = arvalid_q;
        err_d     = err_q;
        outs_d    = outs_q + OW'(hs) - OW'(b_take);

        if (b_take && (bresp_i != 2'b00)) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                arvalid_d = 1'b0;
                if (start_i && (start_beats != '0)) begin
                    src_d   = src_addr_i;
                    dst_d   = dst_addr_i;
                    rem_d   = start_beats;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    src_d = src_q + burst_bytes;
                    dst_d = dst_q + burst_bytes;
                    rem_d = rem_q - LEN_W'(beats);
                    if (rem_d == '0) begin
                        arvalid_d = 1'b0;
                        state_d   = DRAIN;
                    end else begin
                        // back-to-back request allowed with the updated state
                        arvalid_d = !fifo_full_i && (outs_d < MAX_O);
                    end
                end else if (!arvalid_q) begin
                    arvalid_d = !fifo_full_i && (outs_d < MAX_O);
                end
            end
            DRAIN: begin
                arvalid_d = 1'b0;
                if (outs_d == '0) state_d = IDLE;
            end
            default: begin
                arvalid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        done_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            outs_q    <= '0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            outs_q    <= outs_d;
            arvalid_q <= arvalid_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign done_o         = done_q;
    assign err_o          = err_q;
    assign araddr_o       = src_q;
    assign arlen_o        = 8'(beats - CW'(1));
    assign arsize_o       = 3'(SZ);
    assign arburst_o      = 2'b01;
    assign arvalid_o      = arvalid_q & ~rst;
    assign bready_o       = ~rst;
    assign meta_awaddr_o  = dst_q;
    assign meta_awlen_o   = arlen_o;
    assign meta_awvalid_o = hs;

endmodule
